// File: rtl/pipe_pkg.sv
// Shared types and default widths for the generic inter-stage pipeline register.
// Contents: state encoding, default widths, packed MEM/WB control layout.
package pipe_pkg;

  localparam int unsigned RD_W_DEF = 5;
  localparam int unsigned XLEN     = 64;

  // Occupancy of the stage: EMPTY (main invalid), FULL (main only), SKID (main + skid)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // Control bundle carried by the MEM/WB instance
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } memwb_ctrl_t;

  localparam int unsigned MEMWB_CTRL_W = $bits(memwb_ctrl_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; adds 0..2 per cycle and sticks at all-ones.
// Ports: clk, reset (sync, active-high), inc_i (increment 0..2), cnt_o (registered count).
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum;

  // One extra bit catches the wrap so the count can clamp at all-ones
  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and control masking on bubbles.
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall_cnt / flush_cnt counters.
// Ports:
//   clk, reset (sync, active-high), flush (sync discard of held entries)
//   in_valid/in_ready/in_data/in_ctrl/in_rd      upstream side, in_ready registered
//   out_valid/out_ready/out_data/out_ctrl/out_rd downstream side, driven from flops
//   stall_cnt, flush_cnt                         only with PIPE_STAGE_PERF_EN
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 2 * XLEN,
  parameter int unsigned CTRL_W = MEMWB_CTRL_W,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  pipe_state_t       state_q, state_d;

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [RD_W-1:0]   main_rd_q,   main_rd_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [RD_W-1:0]   skid_rd_q,   skid_rd_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next-state logic; flush always returns to EMPTY
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) state_d = FULL;
        FULL: begin
          if (in_xfer && !out_xfer)      state_d = SKID;
          else if (!in_xfer && out_xfer) state_d = EMPTY;
        end
        SKID:    if (out_xfer) state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath and handshake next values; flush drops the input and keeps stale data
  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_rd_d   = main_rd_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rd_d   = skid_rd_q;
    if (!flush) begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            main_rd_d   = in_rd;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            main_rd_d   = in_rd;
          end else if (in_xfer) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            skid_rd_d   = in_rd;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            main_rd_d   = skid_rd_q;
          end
        end
        default: ;
      endcase
    end
    in_ready_d  = (state_d != SKID);
    out_valid_d = (state_d != EMPTY);
    // Control is stored pre-masked so a bubble can never assert a write enable
    main_ctrl_d = main_ctrl_d & {CTRL_W{out_valid_d}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_rd_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_rd_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_rd_q   <= main_rd_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_rd_q   <= skid_rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_rd    = main_rd_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [1:0] stall_inc;
  logic [1:0] held_n;
  logic [1:0] flush_inc;

  // A main entry taken by downstream in the flush cycle is not counted as discarded
  always_comb begin
    stall_inc = {1'b0, out_valid_q & ~out_ready};
    held_n    = 2'(out_valid_q) + 2'(state_q == SKID);
    flush_inc = flush ? (held_n - 2'(out_xfer)) : 2'd0;
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 2;
  localparam int unsigned RW = 5;
  localparam int unsigned NW = 4;
  localparam int          SAT = 15;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [RW-1:0] in_rd, out_rd;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .CNT_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a 2-deep FIFO, ready whenever it is not full
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_rd;
  int            m_stall, m_flush, m_held;
  bit            m_ix, m_ox;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_data  = '0;
      m_rd    = '0;
      m_stall = 0;
      m_flush = 0;
      chk_en  = 1'b1;
    end else begin
      m_held = mq.size();
      m_ix   = in_valid && (m_held != 2);
      m_ox   = out_ready && (m_held > 0);
      if (m_held > 0 && !out_ready) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
      if (flush) begin
        m_flush = (m_flush + m_held - int'(m_ox) > SAT) ? SAT : m_flush + m_held - int'(m_ox);
        mq.delete();
      end else begin
        if (m_ox) void'(mq.pop_front());
        if (m_ix) mq.push_back(ent_t'{d: in_data, c: in_ctrl, r: in_rd});
      end
      if (mq.size() > 0) begin
        m_data = mq[0].d;
        m_rd   = mq[0].r;
      end
    end
  end

  // Compare every cycle once the first reset has been seen
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  DW'(in_ready),  DW'(mq.size() != 2));
      check("out_valid", DW'(out_valid), DW'(mq.size() > 0));
      check("out_ctrl",  DW'(out_ctrl),  (mq.size() > 0) ? DW'(mq[0].c) : '0);
      check("out_data",  out_data,       m_data);
      check("out_rd",    DW'(out_rd),    DW'(m_rd));
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", DW'(stall_cnt), DW'(m_stall));
      check("flush_cnt", DW'(flush_cnt), DW'(m_flush));
`endif
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic [RW-1:0] r, input bit ordy, input bit fl, input bit rst);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_rd     = r;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0; in_rd = '0;

    cyc(0, '0, 2'b00, '0, 0, 0, 1);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_in_ready",  DW'(in_ready),  DW'(1));
    check("rst_out_data",  out_data,       '0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      cyc(1, DW'(i), 2'b11, RW'(i), 1, 0, 0);
      check("stream_data",  out_data,       DW'(i));
      check("stream_valid", DW'(out_valid), DW'(1));
      check("stream_ready", DW'(in_ready),  DW'(1));
    end

    // Bubble masking
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 2'b11, '0, 1, 0, 0);
      check("bubble_valid", DW'(out_valid), '0);
      check("bubble_ctrl",  DW'(out_ctrl),  '0);
      check("bubble_hold",  out_data,       DW'(7));
    end

    // Back-pressure
    cyc(1, 'h11, 2'b11, 5'd1, 0, 0, 0);
    check("bp_a_ready", DW'(in_ready), DW'(1));
    cyc(1, 'h22, 2'b10, 5'd2, 0, 0, 0);
    check("bp_b_ready", DW'(in_ready), '0);
    check("bp_b_data",  out_data,      'h11);
    cyc(1, 'h33, 2'b01, 5'd3, 0, 0, 0);
    check("bp_c_held",  DW'(in_ready), '0);
    check("bp_c_data",  out_data,      'h11);
    cyc(1, 'h33, 2'b01, 5'd3, 1, 0, 0);
    check("bp_out_b",   out_data,      'h22);
    check("bp_b_ctrl",  DW'(out_ctrl), DW'(2'b10));
    cyc(1, 'h33, 2'b01, 5'd3, 1, 0, 0);
    check("bp_out_c",   out_data,      'h33);
    cyc(0, '0, 2'b00, '0, 1, 0, 0);
    check("bp_drained", DW'(out_valid), '0);

    // Flush from SKID with an input offered
    cyc(1, 'hA1, 2'b11, 5'd4, 0, 0, 0);
    cyc(1, 'hB2, 2'b11, 5'd5, 0, 0, 0);
    cyc(1, 'h44, 2'b11, 5'd6, 0, 1, 0);
    check("fl_valid", DW'(out_valid), '0);
    check("fl_ctrl",  DW'(out_ctrl),  '0);
    check("fl_ready", DW'(in_ready),  DW'(1));
    check("fl_hold",  out_data,       'hA1);
`ifdef PIPE_STAGE_PERF_EN
    check("fl_cnt",   DW'(flush_cnt), DW'(2));
`endif
    for (int i = 0; i < 2; i++) begin
      cyc(0, '0, 2'b00, '0, 1, 0, 0);
      check("fl_no_44", DW'(out_valid), '0);
    end

    // Reset mid-operation overriding flush
    cyc(1, 'h55, 2'b11, 5'd7, 0, 0, 0);
    cyc(1, 'h66, 2'b11, 5'd8, 0, 0, 0);
    cyc(1, 'h77, 2'b11, 5'd9, 0, 1, 1);
    check("mr_valid", DW'(out_valid), '0);
    check("mr_data",  out_data,       '0);
    check("mr_ctrl",  DW'(out_ctrl),  '0);
    check("mr_rd",    DW'(out_rd),    '0);
    check("mr_ready", DW'(in_ready),  DW'(1));
    cyc(1, 'h88, 2'b11, 5'd9, 1, 0, 0);
    check("mr_next_valid", DW'(out_valid), DW'(1));
    check("mr_next_data",  out_data,       'h88);
    check("mr_next_rd",    DW'(out_rd),    DW'(9));
    cyc(0, '0, 2'b00, '0, 1, 0, 0);

    // Long stall for counter saturation
    cyc(1, 'h99, 2'b01, 5'd10, 0, 0, 1);
    cyc(1, 'h99, 2'b01, 5'd10, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, '0, 2'b00, '0, 0, 0, 0);
    check("sat_valid", DW'(out_valid), DW'(1));
`ifdef PIPE_STAGE_PERF_EN
    check("sat_stall", DW'(stall_cnt), DW'(15));
`endif
    cyc(0, '0, 2'b00, '0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          {$urandom, $urandom, $urandom, $urandom},
          CW'($urandom_range(0, 3)),
          RW'($urandom_range(0, 31)),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
